// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the matrix ALU scheduler: op codes, bus width helpers
// and the scheduler state encoding.
package matrix_alu_pkg;

  localparam logic [1:0] OP_0 = 2'b00;
  localparam logic [1:0] OP_1 = 2'b01;
  localparam logic [1:0] OP_2 = 2'b10;
  localparam logic [1:0] OP_3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int aw_f(input int rows, input int cols, input int ws);
    return rows * cols * ws;
  endfunction

  function automatic int bw_f(input int rows, input int cols, input int ws);
    return rows * cols * ws;
  endfunction

  function automatic int cw_f(input int ar, input int ac, input int br, input int bc, input int ws);
    return ar * ac * br * bc * ws;
  endfunction

endpackage

// File: rtl/matrix_alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or
// above the pointer, wrapping around.
module rr_arbiter
  import matrix_alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = clog2_f(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_req
);

  logic [IDW-1:0] idx_sel;

  // Walk from the farthest offset down so the nearest active request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx_sel   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx_sel = IDW'((int'(ptr) + off) % NUM_REQ);
      if (req[idx_sel]) begin
        grant          = '0;
        grant[idx_sel] = 1'b1;
        grant_idx      = idx_sel;
        any_req        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_alu_sched.sv
// Shares one matrix ALU between NUM_REQ requesters: accept one job, hold the
// operands on the ALU for ALU_LAT cycles, capture C and return it with the ID.
module matrix_alu_sched
  import matrix_alu_pkg::*;
#(
  parameter int word_size     = 8,
  parameter int Amatrixrownum = 2,
  parameter int Amatrixcolnum = 2,
  parameter int Bmatrixrownum = 2,
  parameter int Bmatrixcolnum = 2,
  parameter int NUM_REQ       = 4,
  parameter int ALU_LAT       = 2,
  localparam int AW  = aw_f(Amatrixrownum, Amatrixcolnum, word_size),
  localparam int BW  = bw_f(Bmatrixrownum, Bmatrixcolnum, word_size),
  localparam int CW  = cw_f(Amatrixrownum, Amatrixcolnum, Bmatrixrownum, Bmatrixcolnum, word_size),
  localparam int IDW = clog2_f(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*AW-1:0] req_a,
  input  logic [NUM_REQ*BW-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]  req_op,
  output logic [AW-1:0]         alu_a,
  output logic [BW-1:0]         alu_b,
  output logic [1:0]            alu_op,
  input  logic [CW-1:0]         alu_c,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [CW-1:0]         rsp_c,
  output logic                  busy
);

  localparam int CNTW = clog2_f(ALU_LAT + 1);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]  alu_a_q, alu_a_d;
  logic [BW-1:0]  alu_b_q, alu_b_d;
  logic [1:0]     alu_op_q, alu_op_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [CW-1:0]  rsp_c_q, rsp_c_d;

  logic [AW-1:0]  a_slice  [NUM_REQ];
  logic [BW-1:0]  b_slice  [NUM_REQ];
  logic [1:0]     op_slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign a_slice[gi]  = req_a[gi*AW +: AW];
    assign b_slice[gi]  = req_b[gi*BW +: BW];
    assign op_slice[gi] = req_op[gi*2 +: 2];
  end

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_c_d     = rsp_c_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          alu_a_d  = a_slice[grant_idx];
          alu_b_d  = b_slice[grant_idx];
          alu_op_d = op_slice[grant_idx];
          rsp_id_d = grant_idx;
          cnt_d    = CNTW'(ALU_LAT - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_c_d     = alu_c;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (rsp_id_q == IDW'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_c_q     <= rsp_c_d;
    end
  end

  // Ready is held low while reset is asserted even though the state reads IDLE.
  assign req_ready = (state_q == IDLE && !resetn) ? grant : '0;
  assign busy      = (state_q != IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_c     = rsp_c_q;

endmodule

// File: doc/matrix_alu_sched.md
Name: matrix_alu_sched

Overview:
Round-robin scheduler that shares one matrix_alu instance between NUM_REQ requesters. It accepts one {A, B, op} job at a time over a valid/ready handshake and drives the ALU operand and op inputs from internal registers. It waits a fixed ALU_LAT cycles, captures C, and returns the result with the requester ID on a valid/ready response channel. It sits between the requesting engines and the matrix_alu, which keeps its own clocking and reset.

Parameters:
word_size, 8, bits per matrix element
Amatrixrownum, 2, rows of A
Amatrixcolnum, 2, columns of A
Bmatrixrownum, 2, rows of B
Bmatrixcolnum, 2, columns of B
NUM_REQ, 4, number of requesters (>=2)
ALU_LAT, 2, cycles from operand update to a valid alu_c (>=1)
Derived: AW = Arow*Acol*word_size; BW = Brow*Bcol*word_size; CW = Arow*Acol*Brow*Bcol*word_size; IDW = clog2(NUM_REQ).

Ports:
clk  in  1  single clock, rising edge
resetn  in  1  asynchronous, active-high reset (resetn=1 resets)
req_valid  in  NUM_REQ  per-requester job valid
req_ready  out  NUM_REQ  one-hot accept strobe
req_a  in  NUM_REQ*AW  A operands, requester i at slice i
req_b  in  NUM_REQ*BW  B operands
req_op  in  NUM_REQ*2  op codes
alu_a  out  AW  to matrix_alu A
alu_b  out  BW  to matrix_alu B
alu_op  out  2  to matrix_alu op
alu_c  in  CW  from matrix_alu C
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_id  out  IDW  requester that issued the job
rsp_c  out  CW  captured result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert): state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_c=0; alu_a=0; alu_b=0; alu_op=2'b00; rr pointer=0 (requester 0 has top priority); wait counter=0. Reset mid-job abandons the job with no response.
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE, winner selection:
  - Winner is the first requester with req_valid=1, searching from the rr pointer upward with wrap.
  - req_ready[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - At that edge: latch winner's slices into alu_a/alu_b/alu_op, latch rsp_id=winner, load counter=ALU_LAT-1, go to WAIT.
- IDLE with no valid request: stay in IDLE; outputs hold their last values.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==0, capture rsp_c<=alu_c and go to RESP.
  - Net timing: capture edge is ALU_LAT edges after the accept edge.
- RESP:
  - rsp_valid=1. rsp_c and rsp_id stay stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, rr pointer<=(rsp_id+1) mod NUM_REQ, go to IDLE.
- req_ready is 0 in WAIT and RESP. Exactly one job is in flight.
- Minimum issue interval is ALU_LAT+2 cycles.
- alu_a/alu_b/alu_op are registered and held stable from accept until the next accept.
- Requester rule: once req_valid is raised, hold it and the operands stable until ready. The bench asserts this; the RTL does not check it.
- op is opaque: passed through unmodified.
- Simultaneous valids on all requesters after reset are served in order 0,1,2,3,0,...
- A new request arriving while busy waits; it is not dropped.

Decomposition:
- Package matrix_alu_pkg: op code localparams (2-bit), width functions AW/BW/CW, clog2 helper, state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
- Sub-module rr_arbiter #(NUM_REQ):
  - inputs: req vector, pointer
  - outputs: one-hot grant, binary grant index, any_req
  - purely combinational
- The top level holds the FSM, counter and registers.

Test Plan:
- Reset: assert resetn mid-WAIT -> within the same cycle state=IDLE, rsp_valid=0, alu_op=00, alu_a=0. The job is never responded to.
- Single job: req0 A={01,02,03,00}, B={05,06,07,08}, op=01, ALU_LAT=2, stub ALU alu_c={op,A,B} registered -> req_ready[0] for 1 cycle; rsp_valid rises 2 edges after accept; rsp_id=0; rsp_c equals the stub value.
- Fairness: all 4 requesters valid from reset with op=00..11 -> rsp_id sequence 0,1,2,3. Each rsp_c matches the respective operands. Issue interval is 4 cycles with rsp_ready=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_c stable. req_ready stays 0 despite req1 valid. req1 is accepted the cycle after the handshake.
- Rotation/wrap: pointer at 3, req3 and req0 both valid -> 3 granted first, then 0. Pointer wraps to 0 after 3 completes.
- Integration: real matrix_alu instance with ALU_LAT set to its latency, ops 00..11 on the vectors above -> rsp_c equals the direct matrix_alu result for each op.
